// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared types and constants for the MEM-stage load/store unit:
//                FSM state encoding, access size codes, byte-lane geometry
//                and the alignment/size fault helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Byte-lane geometry of the 32-bit data word (little-endian lanes)
    localparam int c_LANE_W    = 8;
    localparam int c_NUM_LANES = 4;
    localparam int c_WORD_W    = c_LANE_W * c_NUM_LANES;
    localparam int c_HALF_W    = 2 * c_LANE_W;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Misaligned half/word or reserved size code
    function automatic logic size_fault(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response channel between the pipeline and the
//                load/store unit, plus the word-wide data memory port.
//                master : the load/store unit (drives memory strobes)
//                slave  : the environment (pipeline requester + memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    // Response
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] load_data;
    // Data memory port
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, load_data,
        output memRead, memWrite, Address, writeData,
        input  readData
    );

    modport slave (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, load_data,
        input  memRead, memWrite, Address, writeData,
        output readData
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering. Extracts and extends the
//                addressed lane(s) of a read word for loads, and merges store
//                data into the addressed lane(s) of the read word for stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_pkg::*;
(
    input  wire logic [1:0]          addr_lo_i,
    input  wire logic [1:0]          size_i,
    input  wire logic                signed_i,
    input  wire logic [c_WORD_W-1:0] readData_i,
    input  wire logic [c_WORD_W-1:0] wdata_i,
    output logic      [c_WORD_W-1:0] load_data_o,
    output logic      [c_WORD_W-1:0] merged_o
);

    logic [c_LANE_W-1:0] w_byte;
    logic [c_HALF_W-1:0] w_half;

    // Select the addressed byte and half-word from the read word
    always_comb begin
        w_byte = readData_i[c_LANE_W*addr_lo_i +: c_LANE_W];
        w_half = addr_lo_i[1] ? readData_i[c_WORD_W-1:c_HALF_W]
                              : readData_i[c_HALF_W-1:0];
    end

    // Sign- or zero-extend the extracted lane(s); word loads pass straight through
    always_comb begin
        load_data_o = readData_i;
        case (size_i)
            SZ_B:    load_data_o = {{(c_WORD_W-c_LANE_W){signed_i & w_byte[c_LANE_W-1]}}, w_byte};
            SZ_H:    load_data_o = {{(c_WORD_W-c_HALF_W){signed_i & w_half[c_HALF_W-1]}}, w_half};
            default: load_data_o = readData_i;
        endcase
    end

    // Replace only the addressed lane(s) of the read word with low store data bits
    always_comb begin
        merged_o = readData_i;
        case (size_i)
            SZ_B:    merged_o[c_LANE_W*addr_lo_i +: c_LANE_W] = wdata_i[c_LANE_W-1:0];
            SZ_H:    merged_o[c_HALF_W*addr_lo_i[1] +: c_HALF_W] = wdata_i[c_HALF_W-1:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage load/store initiator. Every accepted request does
//                one aligned word read; stores follow it with a write of the
//                merged word at the same address. Faulty requests complete
//                one cycle after acceptance without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 65536
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mem_access_unit_if.master bus
);

    state_t              state_q, state_d;

    logic                store_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [1:0]          addr_lo_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   address_q;
    logic [DATA_W-1:0]   write_data_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                resp_err_q;

    logic                w_accept;
    logic                w_req_err;
    logic [DATA_W-1:0]   w_load_ext;
    logic [DATA_W-1:0]   w_merged;

    // Request acceptance and fault classification (range limit keeps the whole word in memory)
    always_comb begin
        w_accept  = bus.req_valid && (state_q == ST_IDLE);
        w_req_err = size_fault(bus.req_size, bus.req_addr[1:0])
                 || (bus.req_addr >= ADDR_W'(MEM_DEPTH - 3));
    end

    mem_lane_align u_lane_align (
        .addr_lo_i   (addr_lo_q),
        .size_i      (size_q),
        .signed_i    (signed_q),
        .readData_i  (bus.readData),
        .wdata_i     (wdata_q),
        .load_data_o (w_load_ext),
        .merged_o    (w_merged)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: read always precedes write so the write lands on the same address
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = w_req_err ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_d = store_q ? ST_WR : ST_DONE;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; strobes drop as soon as reset forces IDLE
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.memRead    = (state_q == ST_RD);
        bus.memWrite   = (state_q == ST_WR);
        bus.resp_valid = (state_q == ST_DONE);
        bus.resp_err   = resp_err_q;
        bus.load_data  = load_data_q;
        bus.Address    = address_q;
        bus.writeData  = write_data_q;
    end

    // Request latch on accept, then load result or merged store word captured in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q      <= 1'b0;
            size_q       <= SZ_B;
            signed_q     <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_q      <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            load_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                store_q    <= bus.req_store;
                size_q     <= bus.req_size;
                signed_q   <= bus.req_signed;
                addr_lo_q  <= bus.req_addr[1:0];
                wdata_q    <= bus.req_wdata;
                resp_err_q <= w_req_err;
                if (w_req_err) begin
                    load_data_q <= '0;
                end else begin
                    address_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                end
            end
            if (state_q == ST_RD) begin
                if (store_q) begin
                    write_data_q <= w_merged;
                end else begin
                    load_data_q <= w_load_ext;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                word memory model indexed by the aligned byte address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk;
    logic rst_n;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(65536)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read during memRead, write at the edge ending WR
    logic [31:0] mem [0:65535];
    assign bus.readData = bus.memRead ? mem[bus.Address[15:0]] : 32'h0;
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.Address[15:0]] <= bus.writeData;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_rvalid_in_rst = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request and observe strobes until the response (bounded)
    task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int nrd, output int nwr,
                          output logic [31:0] ra, output logic [31:0] wa,
                          output logic [31:0] wdat, output logic err, output logic [31:0] ld);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; ra = '0; wa = '0; wdat = '0; err = 1'b0; ld = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.memRead)  begin nrd++; ra = bus.Address; end
            if (bus.memWrite) begin nwr++; wa = bus.Address; wdat = bus.writeData; end
            if (bus.resp_valid) begin
                lat = c; err = bus.resp_err; ld = bus.load_data;
                break;
            end
        end
    endtask

    task automatic run_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] exp);
        int lat, nrd, nwr; logic [31:0] ra, wa, wdat, ld; logic err;
        do_req(1'b0, sz, sg, a, 32'h0, lat, nrd, nwr, ra, wa, wdat, err, ld);
        check_eq({tag, " latency"}, lat, 2);
        check_eq({tag, " rd pulses"}, nrd, 1);
        check_eq({tag, " wr pulses"}, nwr, 0);
        check_eq({tag, " rd addr"}, ra, {a[31:2], 2'b00});
        check_eq({tag, " err"}, {31'h0, err}, 0);
        check_eq({tag, " data"}, ld, exp);
    endtask

    task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_word);
        int lat, nrd, nwr; logic [31:0] ra, wa, wdat, ld; logic err;
        do_req(1'b1, sz, 1'b0, a, wd, lat, nrd, nwr, ra, wa, wdat, err, ld);
        check_eq({tag, " latency"}, lat, 3);
        check_eq({tag, " rd pulses"}, nrd, 1);
        check_eq({tag, " wr pulses"}, nwr, 1);
        check_eq({tag, " rd addr"}, ra, {a[31:2], 2'b00});
        check_eq({tag, " wr addr"}, wa, {a[31:2], 2'b00});
        check_eq({tag, " wdata"}, wdat, exp_word);
        check_eq({tag, " err"}, {31'h0, err}, 0);
    endtask

    task automatic run_err(input string tag, input logic st, input logic [1:0] sz,
                           input logic [31:0] a);
        int lat, nrd, nwr; logic [31:0] ra, wa, wdat, ld; logic err;
        do_req(st, sz, 1'b0, a, 32'hDEAD_BEEF, lat, nrd, nwr, ra, wa, wdat, err, ld);
        check_eq({tag, " latency"}, lat, 1);
        check_eq({tag, " err"}, {31'h0, err}, 1);
        check_eq({tag, " rd pulses"}, nrd, 0);
        check_eq({tag, " wr pulses"}, nwr, 0);
        check_eq({tag, " data"}, ld, 0);
    endtask

    // Count responses that appear while reset is asserted or just after an abort
    always @(negedge clk) begin
        if (!rst_n && bus.resp_valid) n_rvalid_in_rst++;
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[1000] = 32'd56;
        mem[1004] = 32'd5;
        mem[1008] = 32'd4;
        mem[1012] = 32'd6;
        mem[65532] = 32'hCAFE_F00D;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst memRead",    {31'h0, bus.memRead}, 0);
        check_eq("rst memWrite",   {31'h0, bus.memWrite}, 0);
        check_eq("rst Address",    bus.Address, 0);
        check_eq("rst writeData",  bus.writeData, 0);
        check_eq("rst req_ready",  {31'h0, bus.req_ready}, 1);
        check_eq("rst resp_valid", {31'h0, bus.resp_valid}, 0);
        check_eq("rst resp_err",   {31'h0, bus.resp_err}, 0);
        check_eq("rst load_data",  bus.load_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word load
        run_load("lw 1000", 2'b10, 1'b0, 32'd1000, 32'd56);
        // Byte store merge and read-back
        run_store("sb 1005", 2'b00, 32'd1005, 32'h0000_00AB, 32'h0000_AB05);
        check_eq("mem[1004]", mem[1004], 32'h0000_AB05);
        run_load("lw 1004", 2'b10, 1'b0, 32'd1004, 32'h0000_AB05);
        // Byte store then signed/unsigned byte and half loads
        run_store("sb 1009", 2'b00, 32'd1009, 32'h0000_0080, 32'h0000_8004);
        run_load("lb 1009",  2'b00, 1'b1, 32'd1009, 32'hFFFF_FF80);
        run_load("lbu 1009", 2'b00, 1'b0, 32'd1009, 32'h0000_0080);
        run_load("lh 1008",  2'b01, 1'b1, 32'd1008, 32'hFFFF_8004);
        run_load("lhu 1008", 2'b01, 1'b0, 32'd1008, 32'h0000_8004);
        // Upper half store and signed lw ignoring req_signed
        run_store("sh 1002", 2'b01, 32'd1002, 32'h1234_9ABC, 32'h9ABC_0038);
        run_load("lw 1000 signed", 2'b10, 1'b1, 32'd1000, 32'h9ABC_0038);
        run_load("lb 1003", 2'b00, 1'b1, 32'd1003, 32'hFFFF_FF9A);
        // Last in-range word
        run_load("lw 65532", 2'b10, 1'b0, 32'd65532, 32'hCAFE_F00D);
        // Errors: load_data was nonzero before, must read 0 after
        run_err("lh 1001", 1'b0, 2'b01, 32'd1001);
        run_err("sw 1002", 1'b1, 2'b10, 32'd1002);
        run_err("rsvd size", 1'b0, 2'b11, 32'd1000);
        run_err("lb 65533", 1'b0, 2'b00, 32'd65533);
        check_eq("mem[1000] after err", mem[1000], 32'h9ABC_0038);

        // Reset during RD of a store
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'd1012; bus.req_wdata = 32'd7;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check_eq("abort in RD", {31'h0, bus.memRead}, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort memRead",  {31'h0, bus.memRead}, 0);
        check_eq("abort memWrite", {31'h0, bus.memWrite}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) n_rvalid_in_rst++;
        end
        check_eq("abort resp_valid", n_rvalid_in_rst, 0);
        check_eq("abort mem[1012]", mem[1012], 32'd6);
        check_eq("abort req_ready", {31'h0, bus.req_ready}, 1);

        // Unit is usable again after the abort
        run_load("lw 1012 post", 2'b10, 1'b0, 32'd1012, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
